alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares one 4-bit `alu` datapath between two requesters.
- Each requester issues an (op, a, b) transaction over a valid/ready handshake. The block arbitrates round-robin, executes one transaction at a time and returns the registered result and flags on a single response channel tagged with the winner's ID.
- Sits between the issuing front-ends and the combinational ALU, so nothing upstream drives the ALU directly.

## Interface
Parameters:
- none; requester count fixed at 2, data width fixed at 4.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  [1:0]  per-requester transaction valid.
- `req_ready`  out  [1:0]  per-requester accept; at most one bit high.
- `req_op`  in  [1:0][2:0]  per-requester opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 INC a, 111 DEC a.
- `req_a`, `req_b`  in  [1:0][3:0]  per-requester operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`  out  4  ALU result.
- `rsp_carry`, `rsp_zero`, `rsp_overflow`  out  1 each  ALU flags.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is combinational from `req_valid` and the `last` pointer.
  - If only one requester is valid, it wins. If both are valid, the requester != `last` wins.
  - `req_ready[grant]` = 1 only in IDLE and only when that requester is valid.
  - On handshake: capture op/a/b into operand regs, the grant into `id_q`, and set `last` = grant. Go to EXEC.
- **EXEC**
  - `alu` is driven from the operand regs.
  - At the next edge, result and all three flags are registered into the output regs, `rsp_id` = `id_q`. Go to RESP.
- **RESP**
  - `rsp_valid` = 1; output regs stay stable until consumed.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- Flags are passed through from `alu` unchanged:
  - carry is bit 4 of the 5-bit sum or difference for ADD/SUB, 0 otherwise;
  - zero is (result == 0);
  - overflow is always 0 from the datapath.
- Request fields not granted are ignored. A requester may change its fields freely while `req_ready` is low.

## Timing
- Reset (`rst_n` = 0 sampled at an edge), from any state:
  - state goes to IDLE, `last` = 1 (requester 0 wins the first contention);
  - `rsp_valid`, `rsp_id`, `rsp_result`, and all flags = 0;
  - `busy` = 0; `req_ready` is forced to 0 while `rst_n` is low.
- Reset mid-transaction: the in-flight transaction is dropped and no response is issued.
- Latency: handshake at edge N, `rsp_valid` high after edge N+1, earliest consume at edge N+2.
- Throughput: at most one transaction per 3 cycles.
- Backpressure: `rsp_ready` low holds RESP indefinitely, with all `rsp_*` outputs stable.
- A requester that deasserts valid in IDLE before its handshake forfeits; this is legal.
- A zero-result INC/DEC wrap (e.g. INC 1111 gives 0000) sets zero = 1 and carry = 0.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum (ADD, SUB, AND, OR, XOR, NOT, INC, DEC as 3'b000–3'b111);
  - `arb_state_t` enum (IDLE, EXEC, RESP);
  - the width constant `ALU_W` = 4.
- One sub-module, the existing `alu`, instantiated once and fed only from the operand regs.
- Arbitration, FSM and output regs live in `alu_arbiter`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with both `req_valid` = 1 → `req_ready` = 00, `rsp_valid` = 0, `busy` = 0.
- **Single request:** req0 ADD a=9 b=8 → accepted at edge N, then `rsp_valid` at N+1 with `rsp_id` = 0, result = 0001, carry = 1, zero = 0.
- **Contention:** both valid continuously, req0 SUB 3-5, req1 INC 15 → responses alternate 0,1,0.
  - req0's response: result = 1110, carry = 1.
  - req1's response: result = 0000, zero = 1, carry = 0.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles in RESP → outputs stable, `req_ready` = 00, then consumed on the first `rsp_ready` = 1.
- **Reset mid-operation:** assert reset in EXEC → no response follows; the next request to req0 is granted first.
- **Zero flag:** ADD 8+8 → result = 0000, carry = 1, zero = 1. AND 1010 & 0101 → result = 0000, zero = 1, carry = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU arbiter slice.
//   ALU_W        operand/result width of the datapath (fixed at 4)
//   NUM_REQ      number of requesters sharing the ALU (fixed at 2)
//   alu_op_t     opcode encoding understood by the alu
//   arb_state_t  arbiter FSM states
package alu_pkg;

  localparam int ALU_W   = 4;
  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_DEC = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request and response channels of the shared-ALU arbiter.
//   req_valid/req_ready   per-requester valid/ready handshake
//   req_op/req_a/req_b    per-requester transaction fields
//   rsp_valid/rsp_ready   single response handshake
//   rsp_id                requester that owns the response
//   rsp_result + flags    registered ALU result, carry, zero, overflow
// The master modport is the front-end side, the slave modport the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][2:0]       req_op;
  logic [NUM_REQ-1:0][ALU_W-1:0] req_a;
  logic [NUM_REQ-1:0][ALU_W-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [ALU_W-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_overflow;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result,
           rsp_carry, rsp_zero, rsp_overflow
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result,
           rsp_carry, rsp_zero, rsp_overflow
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: purely combinational 4-bit datapath.
//   op        opcode (alu_op_t)
//   a, b      operands (b unused by NOT/INC/DEC)
//   result    low ALU_W bits of the operation
//   carry     bit ALU_W of the widened sum/difference for ADD/SUB, else 0
//   zero      result == 0
//   overflow  not produced by this datapath, tied to 0
module alu
  import alu_pkg::*;
(
  input  alu_op_t          op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [ALU_W:0] wide;

  // Every operation is computed one bit wider so ADD/SUB can expose the
  // carry/borrow in the top bit; INC/DEC deliberately report no carry.
  always_comb begin
    wide  = '0;
    carry = 1'b0;
    unique case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        carry = wide[ALU_W];
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        carry = wide[ALU_W];
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_NOT: wide = {1'b0, ~a};
      OP_INC: wide = {1'b0, a} + (ALU_W+1)'(1);
      OP_DEC: wide = {1'b0, a} - (ALU_W+1)'(1);
      default: wide = '0;
    endcase
  end

  assign result   = wide[ALU_W-1:0];
  assign zero     = (result == '0);
  assign overflow = 1'b0;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu between two requesters.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    request/response channels (alu_arbiter_if.slave)
//   busy   high whenever the FSM is not in IDLE
// One transaction is in flight at a time: IDLE accepts, EXEC lets the alu
// settle on the captured operands, RESP holds the registered result until
// the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  arb_state_t       state, state_next;
  logic             last;
  logic             id_q;
  alu_op_t          op_q;
  logic [ALU_W-1:0] a_q, b_q;

  logic             rsp_id_q;
  logic [ALU_W-1:0] result_q;
  logic             carry_q, zero_q, overflow_q;

  logic             grant;
  logic             handshake;

  logic [ALU_W-1:0] alu_result;
  logic             alu_carry, alu_zero, alu_overflow;

  // Round-robin choice: a lone requester always wins; under contention the
  // requester that was not served last time wins.
  always_comb begin
    grant = 1'b0;
    unique case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  // Ready is gated by rst_n so nothing can look accepted while reset is held.
  assign handshake = (state == IDLE) && rst_n && (|bus.req_valid);

  always_comb begin
    bus.req_ready = '0;
    if (handshake) bus.req_ready[grant] = 1'b1;
  end

  // Next-state logic: one cycle of EXEC, then RESP until consumed.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand capture and response registers. Reset drops any
  // in-flight transaction and restores requester 0 as first-contention winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_next;
      if (handshake) begin
        op_q <= alu_op_t'(bus.req_op[grant]);
        a_q  <= bus.req_a[grant];
        b_q  <= bus.req_b[grant];
        id_q <= grant;
        last <= grant;
      end
      if (state == EXEC) begin
        rsp_id_q   <= id_q;
        result_q   <= alu_result;
        carry_q    <= alu_carry;
        zero_q     <= alu_zero;
        overflow_q <= alu_overflow;
      end
    end
  end

  alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_carry    = carry_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = overflow_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// behavioural model (integer arithmetic for the ALU, a winner pointer for
// round-robin).
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;
  int   model_last;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: plain integer arithmetic on the opcode meaning.
  function automatic void model_alu(input int op, input int a, input int b,
                                    output int res, output int carry,
                                    output int zero);
    int s;
    carry = 0;
    case (op)
      0: begin s = a + b; res = s % 16; carry = (s > 15) ? 1 : 0; end
      1: begin s = a - b; res = (s + 16) % 16; carry = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 15 - a;
      6: res = (a + 1) % 16;
      default: res = (a + 15) % 16;
    endcase
    zero = (res == 0) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input int op0, input int a0, input int b0,
                               input int op1, input int a1, input int b1);
    bus.req_valid = valid;
    bus.req_op[0] = 3'(op0);
    bus.req_a[0]  = 4'(a0);
    bus.req_b[0]  = 4'(b0);
    bus.req_op[1] = 3'(op1);
    bus.req_a[1]  = 4'(a1);
    bus.req_b[1]  = 4'(b1);
    #1;
  endtask

  // Runs one full transaction from IDLE, holding the response for 'stall'
  // extra cycles with rsp_ready low.
  task automatic runOne(input string tag, input int stall);
    int win, res, cy, zr, op, a, b;
    logic [3:0] held;
    if (bus.req_valid == 2'b11) win = 1 - model_last;
    else if (bus.req_valid == 2'b10) win = 1;
    else win = 0;
    op = int'(bus.req_op[win]);
    a  = int'(bus.req_a[win]);
    b  = int'(bus.req_b[win]);
    model_alu(op, a, b, res, cy, zr);
    model_last = win;
    checkOutput({tag, ".grant"}, 32'(bus.req_ready), 32'(1 << win));
    bus.rsp_ready = (stall == 0);
    tick();
    checkOutput({tag, ".exec_busy"}, 32'(busy), 1);
    checkOutput({tag, ".exec_valid"}, 32'(bus.rsp_valid), 0);
    checkOutput({tag, ".exec_ready"}, 32'(bus.req_ready), 0);
    tick();
    checkOutput({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
    checkOutput({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(win));
    checkOutput({tag, ".result"}, 32'(bus.rsp_result), 32'(res));
    checkOutput({tag, ".carry"}, 32'(bus.rsp_carry), 32'(cy));
    checkOutput({tag, ".zero"}, 32'(bus.rsp_zero), 32'(zr));
    checkOutput({tag, ".overflow"}, 32'(bus.rsp_overflow), 0);
    held = 4'(res);
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput({tag, ".hold_valid"}, 32'(bus.rsp_valid), 1);
      checkOutput({tag, ".hold_result"}, 32'(bus.rsp_result), 32'(held));
      checkOutput({tag, ".hold_id"}, 32'(bus.rsp_id), 32'(win));
      checkOutput({tag, ".hold_req_ready"}, 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput({tag, ".done_valid"}, 32'(bus.rsp_valid), 0);
    checkOutput({tag, ".done_busy"}, 32'(busy), 0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    model_last    = 1;
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    applyStimulus(2'b11, 0, 1, 2, 0, 3, 4);

    // Reset held for two cycles with both requesters valid.
    tick();
    tick();
    checkOutput("reset.req_ready", 32'(bus.req_ready), 0);
    checkOutput("reset.rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("reset.busy", 32'(busy), 0);
    checkOutput("reset.rsp_result", 32'(bus.rsp_result), 0);
    checkOutput("reset.rsp_id", 32'(bus.rsp_id), 0);
    checkOutput("reset.flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_overflow}), 0);
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Single request: 9 + 8 wraps to 1 with carry.
    applyStimulus(2'b01, 0, 9, 8, 0, 0, 0);
    runOne("single", 0);

    // Contention after a fresh reset: 0 wins first, then alternation.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_last = 1;
    applyStimulus(2'b11, 1, 3, 5, 6, 15, 0);
    runOne("cont0", 0);
    runOne("cont1", 0);
    runOne("cont2", 0);

    // Backpressure for five cycles in RESP.
    applyStimulus(2'b10, 0, 0, 0, 4, 12, 10);
    runOne("bp", 5);

    // Reset during EXEC: the transaction vanishes and req0 wins next.
    applyStimulus(2'b01, 0, 7, 7, 0, 0, 0);
    checkOutput("rstmid.grant", 32'(bus.req_ready), 1);
    tick();
    checkOutput("rstmid.exec_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("rstmid.req_ready_low", 32'(bus.req_ready), 0);
    checkOutput("rstmid.rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("rstmid.busy", 32'(busy), 0);
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_last = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rstmid.no_rsp", 32'(bus.rsp_valid), 0);
    end
    applyStimulus(2'b11, 2, 6, 3, 3, 1, 2);
    runOne("rstmid.after", 0);

    // Zero-flag corner cases.
    applyStimulus(2'b10, 0, 0, 0, 0, 8, 8);
    runOne("zero.add", 0);
    applyStimulus(2'b01, 2, 10, 5, 0, 0, 0);
    runOne("zero.and", 0);
    applyStimulus(2'b01, 7, 1, 0, 0, 0, 0);
    runOne("zero.dec", 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(2'($urandom_range(1, 3)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
      runOne("rand", int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
